// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller: FSM states and the
// bundled enable/flush control word.
package pipeline_ctrl_pkg;

  localparam int DEF_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    PCTRL_RUN      = 2'd0,
    PCTRL_MEM_WAIT = 2'd1,
    PCTRL_ERROR    = 2'd2
  } pctrl_state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_me_en;
    logic me_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_FREEZE   = 7'b00000_00;
  localparam pipe_ctrl_t CTRL_GO       = 7'b11111_00;
  localparam pipe_ctrl_t CTRL_BRANCH   = 7'b11111_11;
  // Hold PC and IF_ID; ID_EX takes a bubble while older stages drain.
  localparam pipe_ctrl_t CTRL_LOAD_USE = 7'b00111_01;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard: the ID instruction reads the register an EX load is
// about to write.
module hazard_detect #(
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  output logic                      load_use
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit  = id_rs1_used && (id_rs1_addr == ex_rd_addr);
  assign rs2_hit  = id_rs2_used && (id_rs2_addr == ex_rd_addr);
  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd_addr != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush controller: combinational enable/flush mux, memory
// wait-state FSM with timeout, and a saturating stall-cycle counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = DEF_REG_ADDR_WIDTH,
  parameter int MEM_TIMEOUT    = 16,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      me_mem_req,
  input  logic                      dmem_ready,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      id_ex_en,
  output logic                      ex_me_en,
  output logic                      me_wb_en,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      mem_timeout_err,
  output logic [CNT_WIDTH-1:0]      stall_cycles
);

  localparam int WCW = $clog2(MEM_TIMEOUT);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  pctrl_state_e   state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_nxt;
  logic           mem_stall, load_use;
  pipe_ctrl_t     ctrl;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard (
    .id_rs1_addr (id_rs1_addr),
    .id_rs2_addr (id_rs2_addr),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd_addr  (ex_rd_addr),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = me_mem_req && !dmem_ready;

  // A frozen pipe holds branch/load-use inputs, so those responses simply
  // issue in the cycle the memory stall clears.
  always_comb begin
    ctrl = CTRL_FREEZE;
    if (rst || state == PCTRL_ERROR) ctrl = CTRL_FREEZE;
    else if (mem_stall)              ctrl = CTRL_FREEZE;
    else if (ex_branch_taken)        ctrl = CTRL_BRANCH;
    else if (load_use)               ctrl = CTRL_LOAD_USE;
    else                             ctrl = CTRL_GO;
  end

  assign pc_en       = ctrl.pc_en;
  assign if_id_en    = ctrl.if_id_en;
  assign id_ex_en    = ctrl.id_ex_en;
  assign ex_me_en    = ctrl.ex_me_en;
  assign me_wb_en    = ctrl.me_wb_en;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      PCTRL_RUN: begin
        if (mem_stall) begin
          state_nxt = PCTRL_MEM_WAIT;
          wait_nxt  = WCW'(1);
        end
      end
      PCTRL_MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt = PCTRL_RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = PCTRL_ERROR;
        end else begin
          wait_nxt  = wait_cnt + 1'b1;
        end
      end
      PCTRL_ERROR: ;
      default: begin
        state_nxt = PCTRL_RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PCTRL_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  assign mem_timeout_err = (state == PCTRL_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cycles <= '0;
    else if (!ctrl.pc_en && state != PCTRL_ERROR && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed + random bench for pipeline_ctrl against a cycle-count reference
// model built from the hazard priority table.
module tb_pipeline_ctrl;

  localparam int MT  = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, ex_rd_addr = '0;
  logic       id_rs1_used = 0, id_rs2_used = 0, ex_mem_read = 0;
  logic       ex_branch_taken = 0, me_mem_req = 0, dmem_ready = 0;
  logic       pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
  logic       if_id_flush, id_ex_flush, mem_timeout_err;
  logic [CW-1:0] stall_cycles;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit m_err;
  int m_run;
  int m_cnt;

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .me_mem_req(me_mem_req),
    .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_me_en(ex_me_en), .me_wb_en(me_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout_err(mem_timeout_err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  wire [6:0] ctl = {pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en, if_id_flush, id_ex_flush};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Priority table: {pc, if_id, id_ex, ex_me, me_wb, if_id_flush, id_ex_flush}
  function automatic logic [6:0] exp_ctl();
    bit lu, ms;
    lu = ex_mem_read && ex_rd_addr != 0 &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) || (id_rs2_used && id_rs2_addr == ex_rd_addr));
    ms = me_mem_req && !dmem_ready;
    if (m_err)                return 7'b0000000;
    else if (ms)              return 7'b0000000;
    else if (ex_branch_taken) return 7'b1111111;
    else if (lu)              return 7'b0011101;
    else                      return 7'b1111100;
  endfunction

  task automatic set_in(input int rs1, input int rs2, input bit u1, input bit u2, input int rd,
                        input bit mr, input bit br, input bit req, input bit rdy);
    id_rs1_addr = 5'(rs1); id_rs2_addr = 5'(rs2);
    id_rs1_used = u1; id_rs2_used = u2; ex_rd_addr = 5'(rd);
    ex_mem_read = mr; ex_branch_taken = br; me_mem_req = req; dmem_ready = rdy;
  endtask

  // Called at a falling edge with inputs applied: check, clock, advance model.
  task automatic cycle();
    logic [6:0] e;
    #1;
    e = exp_ctl();
    chk("ctrl", 32'(ctl), 32'(e));
    chk("timeout_err", 32'(mem_timeout_err), 32'(m_err));
    chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
    @(posedge clk);
    if (!m_err) begin
      if (!e[6]) m_cnt = (m_cnt >= SAT) ? SAT : m_cnt + 1;
      if (me_mem_req && !dmem_ready) begin
        m_run++;
        if (m_run == MT) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
    @(negedge clk);
  endtask

  // Assert reset mid-cycle (away from any edge) with idle inputs.
  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_ctrl", 32'(ctl), 32'd0);
    chk("rst_err", 32'(mem_timeout_err), 32'd0);
    chk("rst_cnt", 32'(stall_cycles), 32'd0);
    m_err = 0; m_run = 0; m_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2;
    chk("por_ctrl", 32'(ctl), 32'd0);
    @(negedge clk);
    do_reset();

    // load-use stall, then rd==0 never stalls
    set_in(5, 0, 1, 0, 5, 1, 0, 0, 0); cycle();
    chk("lu_cnt", 32'(stall_cycles), 32'd1);
    set_in(0, 0, 1, 0, 0, 1, 0, 0, 0); cycle();
    chk("lu_x0_cnt", 32'(stall_cycles), 32'd1);
    set_in(3, 7, 1, 1, 7, 1, 0, 0, 0); cycle();
    // branch overrides load-use
    set_in(5, 0, 1, 0, 5, 1, 1, 0, 0); cycle();
    chk("br_cnt", 32'(stall_cycles), 32'd2);

    // memory wait of 3 cycles, then back-to-back access restarts the count
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (3) cycle();
      dmem_ready = 1; cycle();
    end
    chk("mw_cnt", 32'(stall_cycles), 32'd6);
    chk("mw_err", 32'(mem_timeout_err), 32'd0);

    // freeze beats branch; branch issues when the stall clears
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
    dmem_ready = 1; cycle();

    // timeout: error from cycle MT+1, sticky across dmem_ready
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MT) cycle();
    chk("to_err", 32'(mem_timeout_err), 32'd1);
    repeat (2) cycle();
    dmem_ready = 1; cycle();
    chk("to_sticky", 32'(mem_timeout_err), 32'd1);
    chk("to_cnt_frozen", 32'(stall_cycles), 32'(MT));
    do_reset();

    // ready in the MT-th stall cycle avoids error; withdrawn request -> RUN
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (MT - 1) cycle();
    dmem_ready = 1; cycle();
    me_mem_req = 0; dmem_ready = 0; cycle();
    chk("bnd_err", 32'(mem_timeout_err), 32'd0);
    me_mem_req = 1; repeat (2) cycle();
    me_mem_req = 0; cycle();
    chk("wd_en", 32'(pc_en), 32'd1);

    // saturation, then async reset during a wait
    do_reset();
    for (int r = 0; r < 6; r++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
      repeat (MT - 1) cycle();
      dmem_ready = 1; cycle();
    end
    chk("sat_cnt", 32'(stall_cycles), 32'(SAT));
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) cycle();
    do_reset();

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset();
      set_in($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 4) == 0,
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage pipeline. It generates the enable for the PC and for each inter-stage register (IF_ID, ID_EX, EX_ME, ME_WB), and the bubble-insert flushes for IF_ID and ID_EX. It also sequences data-memory wait states through a small FSM with a timeout, and keeps a saturating stall-cycle counter.

## Interface
- `REG_ADDR_WIDTH`, 5: register address width; matches `` `REG_ADDR_WIDTH `` in Defines.vh.
- `MEM_TIMEOUT`, 16: number of consecutive memory-stall cycles before the error state; legal range ≥ 2.
- `CNT_WIDTH`, 32: width of the stall counter.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `id_rs1_addr`  in  REG_ADDR_WIDTH  rs1 of the instruction in ID.
- `id_rs2_addr`  in  REG_ADDR_WIDTH  rs2 of the instruction in ID.
- `id_rs1_used`  in  1  the ID instruction reads rs1.
- `id_rs2_used`  in  1  the ID instruction reads rs2.
- `ex_rd_addr`  in  REG_ADDR_WIDTH  rd of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_branch_taken`  in  1  EX resolved a taken branch or jump.
- `me_mem_req`  in  1  the ME instruction accesses data memory.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pc_en`  out  1  PC update enable.
- `if_id_en`  out  1  IF_ID register enable.
- `id_ex_en`  out  1  ID_EX register enable.
- `ex_me_en`  out  1  EX_ME register enable.
- `me_wb_en`  out  1  ME_WB register enable.
- `if_id_flush`  out  1  IF_ID loads a bubble at the next edge.
- `id_ex_flush`  out  1  ID_EX loads a bubble at the next edge.
- `mem_timeout_err`  out  1  sticky memory-timeout error.
- `stall_cycles`  out  CNT_WIDTH  count of cycles with `pc_en`=0.

## Operation
- FSM states:
  - RUN: normal operation.
  - MEM_WAIT: memory stall in progress.
  - ERROR: terminal until reset.
- Internal signals:
  - `mem_stall` = `me_mem_req` & !`dmem_ready`.
  - `load_use` = `ex_mem_read` & (`ex_rd_addr`≠0) & ((`id_rs1_used` & rs1==rd) | (`id_rs2_used` & rs2==rd)).
- Output priority, highest first:
  1. ERROR or `rst`: all enables 0, both flushes 0.
  2. `mem_stall`: all five enables 0, both flushes 0. The whole pipe freezes, and the same WB write repeating is harmless.
  3. `ex_branch_taken`: all enables 1, `if_id_flush`=1, `id_ex_flush`=1.
  4. `load_use`: `pc_en`=0, `if_id_en`=0, `id_ex_en`=1 with `id_ex_flush`=1; `ex_me_en`=`me_wb_en`=1.
  5. Otherwise: all enables 1, flushes 0.
- A flush is asserted only when its register's enable is also 1.
- Branch beats load-use: the load-dependent instruction is squashed, so no stall is needed.
- FSM transitions:
  - RUN → MEM_WAIT on `mem_stall`; `wait_cnt`←1.
  - MEM_WAIT, `mem_stall`, `wait_cnt`==MEM_TIMEOUT-1 → ERROR.
  - MEM_WAIT, `mem_stall`, otherwise: stay; `wait_cnt`+1.
  - MEM_WAIT, !`mem_stall` (ready, or request withdrawn) → RUN; `wait_cnt`←0.
  - ERROR → ERROR; only `rst` exits.
- `mem_timeout_err` = (state==ERROR), registered.
- `stall_cycles` increments on every edge where `pc_en`=0 and the state is not ERROR. It saturates at all-ones and does not wrap.

## Timing
- Enables and flushes are combinational from the inputs and the current state; there is no added latency.
- The wait-state count is decided by registered state.
- Reset values: state RUN, `wait_cnt` 0, `mem_timeout_err` 0, `stall_cycles` 0. While `rst` is high, all enables and flushes are 0.
- Memory handshake: the access completes in the cycle `dmem_ready`=1. That cycle all enables are 1, and the pipe advances at that edge.
- Timeout: MEM_TIMEOUT consecutive stalled cycles. The error is visible from the cycle after the MEM_TIMEOUT-th stalled cycle. `dmem_ready` arriving in the MEM_TIMEOUT-th cycle avoids the error.
- Simultaneous `mem_stall` with branch or load-use: the freeze wins. The branch or load-use response is issued in the cycle the stall clears, since the inputs are held by the frozen registers.
- `rst` mid-MEM_WAIT or in ERROR: immediate return to RUN with counters cleared.
- Back-to-back memory accesses re-enter MEM_WAIT with `wait_cnt` restarted at 1.

## Structure
- State encodings go in Defines.vh: `` `PCTRL_RUN `` 2'd0, `` `PCTRL_MEM_WAIT `` 2'd1, `` `PCTRL_ERROR `` 2'd2. `` `REG_ADDR_WIDTH `` is reused from there.
- One sub-module, `hazard_detect`, computes `load_use` combinationally.
- The FSM, `wait_cnt` (width $clog2(MEM_TIMEOUT)), stall counter and output mux live in `pipeline_ctrl`.

## Test plan
- **Load-use:** `ex_mem_read`=1, `ex_rd_addr`=5, `id_rs1_addr`=5 (used), no other events → one cycle of `pc_en`=0, `if_id_en`=0, `id_ex_flush`=1; `stall_cycles` 0→1. Repeating with `ex_rd_addr`=0 → no stall.
- **Branch:** `ex_branch_taken`=1 together with the load-use case → all enables 1, both flushes 1, `stall_cycles` unchanged.
- **Memory wait:** `me_mem_req`=1, `dmem_ready` low for 3 cycles then high → enables 0 for 3 cycles, 1 in the 4th, FSM back to RUN, `stall_cycles`=3.
- **Timeout:** MEM_TIMEOUT=4, `dmem_ready` held 0 → `mem_timeout_err`=1 from cycle 5, all enables 0 thereafter. `dmem_ready`=1 later does not clear it; `rst` does.
- **Boundary:** `dmem_ready` arriving exactly in stall cycle 4 (MEM_TIMEOUT=4) → no error. Request withdrawn mid-wait → RUN.
- **Saturation:** CNT_WIDTH=4, hold a continuous memory stall with MEM_TIMEOUT=32 → `stall_cycles` stops at 15. Async `rst` mid-wait → all outputs 0 immediately.
